// File: rtl/slurm32_cpu_pkg.sv
// Shared SLURM32 core types and constants used by the fetch unit.
package slurm32_cpu_pkg;

  localparam int INSN_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INSN_W-1:0] NOP_INSN          = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, insn} pairs; clear overrides push and pop on the same edge.
module fetch_fifo
  import slurm32_cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RSTb,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic [ADDR_W-1:0]           push_pc,
  input  logic [INSN_W-1:0]           push_insn,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic [ADDR_W-1:0]           head_pc,
  output logic [INSN_W-1:0]           head_insn
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [INSN_W-1:0] insn_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge CLK) begin
    if (!RSTb || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; count gates visibility of the entries.
  always_ff @(posedge CLK) begin
    if (push && !clear) begin
      pc_mem[wr_ptr]   <= push_pc;
      insn_mem[wr_ptr] <= push_insn;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_insn = insn_mem[rd_ptr];

endmodule

// File: rtl/cpu_fetch.sv
// SLURM32 instruction fetch: credit-limited in-order reads, prefetch FIFO, branch flush.
// Optional stall counter port fetch_stall_cnt is enabled by SLURM32_FETCH_STALL_COUNT_EN.
module cpu_fetch
  import slurm32_cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VEC  = DEFAULT_RESET_VEC,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RSTb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [INSN_W-1:0] mem_rd_data,
  output logic [INSN_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_take,
  input  logic [ADDR_W-1:0] branch_target
`ifdef SLURM32_FETCH_STALL_COUNT_EN
  ,
  output logic [31:0]       fetch_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;

  logic [CNT_W-1:0]  fifo_count, outstanding, drop_cnt;
  logic [CNT_W-1:0]  count_n, outstanding_n, drop_n;
  logic [SUM_W-1:0]  credit_used;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n, ret_pc, head_pc;
  logic [INSN_W-1:0] head_insn;
  logic              stale_req, grant, ret, dropping, push, pop, req_hold, req_n;

  assign grant    = mem_rd_req & mem_rd_gnt;
  assign ret      = mem_rd_valid & (outstanding != '0);
  assign dropping = ret & (drop_cnt != '0);
  assign push     = ret & ~dropping & ~branch_take;
  assign pop      = instr_valid & instr_ready & ~branch_take;
  assign req_hold = mem_rd_req & ~mem_rd_gnt;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .push      (push),
    .pop       (pop),
    .clear     (branch_take),
    .push_pc   (ret_pc),
    .push_insn (mem_rd_data),
    .count     (fifo_count),
    .head_pc   (head_pc),
    .head_insn (head_insn)
  );

  assign instr_valid = (fifo_count != '0);
  assign instruction = instr_valid ? head_insn : NOP_INSN;
  assign instr_pc    = instr_valid ? head_pc : '0;

  // A grant for a request raised before a branch is owed a return that must be dropped.
  always_comb begin
    outstanding_n = outstanding + CNT_W'(grant) - CNT_W'(ret);
    count_n       = branch_take ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    if (branch_take) begin
      drop_n     = drop_cnt + outstanding_n;
      fetch_pc_n = word_align(branch_target);
    end else begin
      drop_n     = drop_cnt - CNT_W'(dropping) + CNT_W'(grant & stale_req);
      fetch_pc_n = (grant & ~stale_req) ? fetch_pc + ADDR_W'(4) : fetch_pc;
    end
    credit_used = SUM_W'(count_n) + SUM_W'(outstanding_n) + SUM_W'(drop_n);
    req_n       = req_hold | (credit_used < SUM_W'(FIFO_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      mem_rd_req  <= 1'b0;
      mem_addr    <= '0;
      fetch_pc    <= word_align(RESET_VEC);
      ret_pc      <= word_align(RESET_VEC);
      outstanding <= '0;
      drop_cnt    <= '0;
      stale_req   <= 1'b0;
    end else begin
      mem_rd_req  <= req_n;
      if (req_n && !req_hold) mem_addr <= fetch_pc_n;
      fetch_pc    <= fetch_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_n;
      stale_req   <= branch_take ? req_hold : (stale_req & ~grant);
      if (branch_take)
        ret_pc <= word_align(branch_target);
      else if (push)
        ret_pc <= ret_pc + ADDR_W'(4);
    end
  end

`ifdef SLURM32_FETCH_STALL_COUNT_EN
  always_ff @(posedge CLK) begin
    if (!RSTb)
      fetch_stall_cnt <= '0;
    else if (instr_ready && !instr_valid && (fetch_stall_cnt != '1))
      fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
  end
`endif

endmodule
